// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: op codes and FSM state encoding.
package alu_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned STATE_W = 2;

    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_OR  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_XOR = 3'b011;
    localparam logic [OP_W-1:0] OP_SLT = 3'b100;
    localparam logic [OP_W-1:0] OP_MUL = 3'b101;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/adder_nbit.sv
// WIDTH-bit ripple adder with carry-in, carry-out and signed overflow.
module adder_nbit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    assign {cout, sum} = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);
    assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_seq.sv
// Multicycle ALU with registered flags, SLT and a shift-add multiplier,
// valid/ready handshaked on both sides.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ainvert,
    input  logic             binvert,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic               is_slt;
    logic               is_arith;
    logic [WIDTH-1:0]   a_eff, b_eff;
    logic [WIDTH-1:0]   alu_b, alu_sum, alu_res;
    logic               alu_cin, alu_cout, alu_ovf;
    logic [WIDTH-1:0]   acc_addend, acc_sum;
    logic               mul_cout_unused, mul_ovf_unused;

    assign accept   = in_valid && (state_q == ST_IDLE);
    assign is_slt   = (op == OP_SLT);
    assign is_arith = (op == OP_ADD) || is_slt;
    assign a_eff    = ainvert ? ~a : a;
    assign b_eff    = binvert ? ~b : b;

    // SLT always subtracts, regardless of what binvert asks of the adder
    assign alu_b   = is_slt ? ~b_eff : b_eff;
    assign alu_cin = is_slt ? 1'b1 : binvert;

    adder_nbit #(.WIDTH(WIDTH)) u_alu_add (
        .a    (a_eff),
        .b    (alu_b),
        .cin  (alu_cin),
        .sum  (alu_sum),
        .cout (alu_cout),
        .ovf  (alu_ovf)
    );

    assign acc_addend = mplier_q[0] ? mcand_q : '0;

    adder_nbit #(.WIDTH(WIDTH)) u_mul_acc (
        .a    (result_q),
        .b    (acc_addend),
        .cin  (1'b0),
        .sum  (acc_sum),
        .cout (mul_cout_unused),
        .ovf  (mul_ovf_unused)
    );

    always_comb begin
        alu_res = '0;
        case (op)
            OP_AND:  alu_res = a_eff & b_eff;
            OP_OR:   alu_res = a_eff | b_eff;
            OP_XOR:  alu_res = a_eff ^ b_eff;
            OP_ADD:  alu_res = alu_sum;
            OP_SLT:  alu_res = WIDTH'(alu_sum[WIDTH-1] ^ alu_ovf);
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = (op == OP_MUL) ? ST_MUL : ST_DONE;
            ST_MUL:  if (cnt_q == CNT_W'(WIDTH-1)) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (accept && (op == OP_MUL)) begin
                    mcand_d  = a_eff;
                    mplier_d = b_eff;
                    cnt_d    = '0;
                    result_d = '0;
                    zero_d   = 1'b0;
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                end else if (accept) begin
                    result_d = alu_res;
                    zero_d   = (alu_res == '0);
                    carry_d  = is_arith ? alu_cout : 1'b0;
                    ovf_d    = is_arith ? alu_ovf : 1'b0;
                end
            end
            // one partial product per cycle, accumulated in the result register
            ST_MUL: begin
                result_d = acc_sum;
                zero_d   = (acc_sum == '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: vector table plus reset and backpressure sequences.
module tb_alu_seq;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ainvert;
    logic         binvert;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ai;
        logic         bi;
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
        int           lat;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ainvert   (ainvert),
        .binvert   (binvert),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op at a negedge, scramble inputs after accept, then check latency and outputs.
    task automatic run_op(input vec_t v, input string tag);
        int lat;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        op = v.op; a = v.a; b = v.b; ainvert = v.ai; binvert = v.bi;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op = 3'(~v.op); a = ~v.a; b = v.a ^ v.b; ainvert = ~v.ai; binvert = ~v.bi;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(v.lat));
        chk({tag, ".result"},  32'(result),   32'(v.res));
        chk({tag, ".zero"},    32'(zero),     32'(v.z));
        chk({tag, ".carry"},   32'(carry),    32'(v.c));
        chk({tag, ".ovf"},     32'(overflow), 32'(v.v));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".ov_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        //          op      a      b      ai    bi    res    z     c     v     lat
        vecs[0]  = '{3'b010, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1};
        vecs[1]  = '{3'b010, 8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1};
        vecs[2]  = '{3'b100, 8'hFE, 8'h03, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 1};
        vecs[3]  = '{3'b100, 8'h03, 8'hFE, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1};
        vecs[4]  = '{3'b101, 8'h0D, 8'h0B, 1'b0, 1'b0, 8'h8F, 1'b0, 1'b0, 1'b0, 9};
        vecs[5]  = '{3'b000, 8'hF0, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1};
        vecs[6]  = '{3'b001, 8'hF0, 8'h0F, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1};
        vecs[7]  = '{3'b011, 8'hA5, 8'hFF, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{3'b010, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1};
        vecs[9]  = '{3'b010, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b1, 1};
        vecs[10] = '{3'b110, 8'h12, 8'h34, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1};
        vecs[11] = '{3'b101, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 9};
        vecs[12] = '{3'b101, 8'hF2, 8'h0B, 1'b1, 1'b0, 8'h8F, 1'b0, 1'b0, 1'b0, 9};
        vecs[13] = '{3'b101, 8'h00, 8'h37, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 9};
        vecs[14] = '{3'b111, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; ainvert = 1'b0; binvert = 1'b0; op = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready",  32'(in_ready),  32'd1);
        chk("rst.result",    32'(result),    32'd0);
        chk("rst.zero",      32'(zero),      32'd0);
        chk("rst.carry",     32'(carry),     32'd0);
        chk("rst.ovf",       32'(overflow),  32'd0);

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a multiply aborts it.
        op = 3'b101; a = 8'h0D; b = 8'h0B; ainvert = 1'b0; binvert = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midmul.rst_ov",  32'(out_valid), 32'd0);
        chk("midmul.rst_res", 32'(result),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midmul.in_ready", 32'(in_ready),  32'd1);
        chk("midmul.ov",       32'(out_valid), 32'd0);
        chk("midmul.res",      32'(result),    32'd0);
        repeat (10) @(negedge clk);
        chk("midmul.no_done", 32'(out_valid), 32'd0);

        // Backpressure: result holds, new requests are ignored and not queued.
        op = 3'b010; a = 8'h12; b = 8'h34; ainvert = 1'b0; binvert = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        op = 3'b011; a = 8'hFF; b = 8'h00;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d.ov", k),  32'(out_valid), 32'd1);
            chk($sformatf("bp%0d.res", k), 32'(result),    32'h46);
            chk($sformatf("bp%0d.rdy", k), 32'(in_ready),  32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp.idle_rdy", 32'(in_ready),  32'd1);
        chk("bp.idle_ov",  32'(out_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("bp.not_queued", 32'(out_valid), 32'd0);
        chk("bp.res_hold",   32'(result),    32'h46);
        run_op(vecs[5], "bp.nor");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
